fifo_rd_stream: RTL and testbench
=================================

Name: fifo_rd_stream

Overview:
- Read-side consumer for the team's async FIFO: drains the FIFO read port (rempty/ren/rdata) in the rclk domain.
- Presents the data as a valid/ready stream through a 2-entry output buffer, sustaining one word per cycle.
- Adds a flush state machine that discards buffered and queued words, plus a delivered-word counter for debug/status.
- Instantiated next to the FIFO, entirely in the read clock domain.

Parameters:
- DATA_WIDTH, 8: width of rdata and m_data.
- CNT_WIDTH, 16: width of xfer_cnt.

Ports:
- clk  input  1  read-domain clock (FIFO rclk)
- reset_n  input  1  asynchronous active-low reset
- rempty  input  1  FIFO empty flag (registered in FIFO)
- ren  output  1  FIFO pop request
- rdata  input  DATA_WIDTH  FIFO read data, valid in the same cycle as ~rempty (combinational RAM read)
- flush  input  1  level request: discard all buffered and queued data
- flush_busy  output  1  high while in FLUSH state
- m_valid  output  1  stream data valid
- m_ready  input  1  stream consumer ready
- m_data  output  DATA_WIDTH  stream data (head of buffer)
- xfer_cnt  output  CNT_WIDTH  count of completed stream handshakes, wraps
- buf_level  output  2  buffer occupancy, 0..2

Behaviour:
- Clocking and reset: one clock (clk); reset_n is asynchronous, active-low.
  - Reset values: state=RUN, buf_level=0, m_valid=0, m_data=0, buf1=0, xfer_cnt=0, flush_busy=0.
  - ren=0 while reset_n=0.
- Storage and outputs:
  - Two registers: buf0 (head) and buf1.
  - m_data=buf0; m_valid=(buf_level!=0) and state==RUN. Both are driven from registers only.
- Handshake terms:
  - pop = ren & ~rempty.
  - deq = m_valid & m_ready.
  - m_data must stay stable while m_valid=1 and m_ready=0.
- ren (combinational):
  - RUN: ren = ~rempty & (buf_level!=2).
  - FLUSH: ren = ~rempty.
  - No dependence on m_ready.
- RUN buffer update (per edge):
  - pop & ~deq: level 0 -> buf0<=rdata, level 1; level 1 -> buf1<=rdata, level 2.
  - deq & ~pop: level 1 -> level 0; level 2 -> buf0<=buf1, level 1.
  - pop & deq: level 1 -> buf0<=rdata, stays 1. Level 2 cannot occur because ren=0 at level 2.
- Throughput and latency:
  - Word visible at FIFO read port in cycle N gives m_valid=1 with that word in cycle N+1.
  - With rempty=0 and m_ready=1 continuously, one word per cycle at level 1.
- Ordering: words leave on m_data in FIFO order; no loss or duplication in RUN.
- FSM:
  - RUN -> FLUSH on any edge where flush=1.
    - At that edge: buf_level<=0 and buffered contents are discarded.
    - A deq in that same cycle still completes and counts.
    - A pop in that same cycle is discarded.
  - FLUSH: flush_busy=1, m_valid=0, every popped word is discarded.
  - FLUSH -> RUN on the first edge where rempty=1 and flush=0.
  - FLUSH only guarantees draining of words already visible through rempty; words the writer adds later are not its concern.
- xfer_cnt:
  - Increments by 1 on every deq.
  - Wraps from 2^CNT_WIDTH-1 to 0.
  - Not cleared by flush.
- Reset mid-transfer: all state returns immediately to reset values; buffered words are lost.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33, m_ready=1 -> m_data sequence 0x11,0x22,0x33 on consecutive cycles; xfer_cnt=3; buf_level returns to 0; ren never asserts while rempty=1.
- Backpressure: 4 words queued, m_ready=0 for 10 cycles -> exactly 2 pops, buf_level=2, ren=0, m_data held at the first word. Then m_ready=1 -> all 4 words in order with no gaps after the first.
- Streaming: 100 words, m_ready=1 -> 100 consecutive handshakes, no bubbles after the first; xfer_cnt=100.
- Random m_ready (50%) over 1000 words -> scoreboard matches FIFO order exactly; buf_level never exceeds 2; no pop when buf_level=2.
- Flush with buf_level=2 and 5 words still in FIFO, flush pulsed 1 cycle -> m_valid=0 next cycle; ren high until rempty=1; flush_busy then drops; FIFO empty; no flushed word appears on m_data; xfer_cnt unchanged.
- CNT_WIDTH=4, 17 handshakes -> xfer_cnt=1 (wrap). Assert reset_n low mid-stream -> outputs return to reset values asynchronously and ren=0.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains an async FIFO read port into a 2-deep valid/ready stream with flush and handshake counter
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rempty,
  output logic                  ren,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  flush,
  output logic                  flush_busy,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  xfer_cnt,
  output logic [1:0]            buf_level
);
  typedef enum logic {RUN, FLUSH} state_e;
  state_e                state_q, state_d;
  logic [1:0]            level_q, level_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  pop, deq;
  // Pop only when there is room (RUN) or unconditionally while discarding (FLUSH); held off during reset
  assign ren        = reset_n && !rempty && (state_q == FLUSH || level_q != 2'd2);
  assign pop        = ren && !rempty;
  assign m_valid    = level_q != 2'd0 && state_q == RUN;
  assign deq        = m_valid && m_ready;
  assign m_data     = buf0_q;
  assign xfer_cnt   = cnt_q;
  assign buf_level  = level_q;
  assign flush_busy = state_q == FLUSH;
  // Next-state: buffer shifting in RUN, discard-until-empty in FLUSH; counter tracks every handshake
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    cnt_d   = cnt_q + CNT_WIDTH'(deq);
    if (state_q == RUN) begin
      if (flush) begin
        state_d = FLUSH;
        level_d = 2'd0;
      end else if (pop && !deq) begin
        buf0_d  = level_q == 2'd0 ? rdata : buf0_q;
        buf1_d  = level_q == 2'd0 ? buf1_q : rdata;
        level_d = level_q + 2'd1;
      end else if (deq && !pop) begin
        buf0_d  = level_q == 2'd2 ? buf1_q : buf0_q;
        level_d = level_q - 2'd1;
      end else if (pop && deq) begin
        buf0_d  = rdata;
      end
    end else if (rempty && !flush) begin
      state_d = RUN;
    end
  end
  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      level_q <= 2'd0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: FIFO model plus scoreboard checking ordering, backpressure, flush, wrap and async reset
module tb_fifo_rd_stream;
  typedef struct {
    int          n;
    int          pct;
    logic [15:0] exp_cnt;
    logic [3:0]  exp_cnt4;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rempty = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        flush = 1'b0;
  logic        m_ready = 1'b0;
  logic        ren, flush_busy, m_valid;
  logic [7:0]  m_data;
  logic [15:0] xfer_cnt;
  logic [1:0]  buf_level;
  logic        ren_n, flush_busy_n, m_valid_n;
  logic [7:0]  m_data_n;
  logic [3:0]  cnt_n;
  logic [1:0]  lvl_n;
  logic [7:0]  fifo[$];
  logic [7:0]  sb[$];
  logic        pop_s = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  int          pass_cnt = 0;
  int          tot = 0;
  int          deq_cnt = 0;
  int          pop_cnt = 0;
  int          pct = 0;
  vec_t        tbl[3];

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .rempty(rempty), .ren(ren), .rdata(rdata),
    .flush(flush), .flush_busy(flush_busy), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .xfer_cnt(xfer_cnt), .buf_level(buf_level)
  );

  fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_narrow (
    .clk(clk), .reset_n(reset_n), .rempty(rempty), .ren(ren_n), .rdata(rdata),
    .flush(flush), .flush_busy(flush_busy_n), .m_valid(m_valid_n), .m_ready(m_ready),
    .m_data(m_data_n), .xfer_cnt(cnt_n), .buf_level(lvl_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  task automatic inv(input string nm, input logic ok);
    tot++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got 0 required 1 at %0t", nm, $time);
  endtask

  // FIFO model: registered empty flag and combinational head, updated just after each edge
  always @(posedge clk) begin
    #1;
    if (pop_s && fifo.size() > 0) void'(fifo.pop_front());
    rempty = fifo.size() == 0;
    rdata  = fifo.size() > 0 ? fifo[0] : rdata;
  end

  // Monitor on the falling edge: invariants, pop tracking and scoreboard compare on each handshake
  always @(negedge clk) begin
    logic [7:0] exp;
    pop_s = reset_n && ren && !rempty;
    if (reset_n) begin
      inv("ren_while_empty", !(rempty && ren));
      inv("level_le2", buf_level <= 2'd2);
      inv("no_pop_at_full", !(ren && buf_level == 2'd2 && !flush_busy));
      inv("no_valid_in_flush", !(flush_busy && m_valid));
      inv("flush_drains", !(flush_busy && !rempty && !ren));
      if (prev_stall && !prev_flush) inv("hold_stable", m_valid && m_data == prev_data);
      if (pop_s) pop_cnt++;
      if (m_valid && m_ready) begin
        deq_cnt++;
        if (sb.size() == 0) inv("deq_unexpected", 1'b0);
        else begin
          exp = sb.pop_front();
          chk("deq_data", m_data, exp);
        end
      end
    end
    prev_stall = reset_n && m_valid && !m_ready;
    prev_flush = flush;
    prev_data  = m_data;
  end

  task automatic step();
    @(posedge clk);
    #2;
    m_ready = pct >= 100 ? 1'b1 : pct <= 0 ? 1'b0 : ($urandom_range(99) < pct);
  endtask

  task automatic push(input logic [7:0] w);
    fifo.push_back(w);
    sb.push_back(w);
  endtask

  task automatic wait_drain(input string nm, input int bound);
    int k;
    for (k = 0; k < bound && (sb.size() != 0 || buf_level != 2'd0); k++) step();
    inv(nm, sb.size() == 0 && buf_level == 2'd0);
  endtask

  task automatic wait_first(input int base);
    int k;
    for (k = 0; k < 20 && deq_cnt == base; k++) step();
    inv("first_deq_timeout", deq_cnt != base);
  endtask

  initial begin
    int base, c0, k;
    tbl[0] = '{n: 17, pct: 100, exp_cnt: 16'd17, exp_cnt4: 4'd1};
    tbl[1] = '{n: 5,  pct: 50,  exp_cnt: 16'd22, exp_cnt4: 4'd6};
    tbl[2] = '{n: 30, pct: 25,  exp_cnt: 16'd52, exp_cnt4: 4'd4};
    repeat (3) step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_level", buf_level, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_busy", flush_busy, 0);
    chk("rst_ren", ren, 0);
    reset_n = 1'b1;
    pct = 100;
    step();
    base = deq_cnt;
    push(8'h11); push(8'h22); push(8'h33);
    wait_first(base);
    repeat (2) step();
    chk("burst3_consec", deq_cnt - base, 3);
    wait_drain("burst3_drain", 20);
    chk("burst3_xfer", xfer_cnt, 3);
    pct = 0;
    step();
    base = pop_cnt;
    push(8'h44); push(8'h55); push(8'h66); push(8'h77);
    repeat (10) step();
    chk("bp_pops", pop_cnt - base, 2);
    chk("bp_level", buf_level, 2);
    chk("bp_ren", ren, 0);
    chk("bp_m_data", m_data, 8'h44);
    pct = 100;
    step();
    base = deq_cnt;
    repeat (4) step();
    chk("bp_release_consec", deq_cnt - base, 4);
    wait_drain("bp_drain", 20);
    chk("bp_xfer", xfer_cnt, 7);
    base = deq_cnt;
    for (int i = 0; i < 100; i++) push(8'(i * 7 + 3));
    wait_first(base);
    repeat (99) step();
    chk("stream100_consec", deq_cnt - base, 100);
    wait_drain("stream100_drain", 20);
    chk("stream100_xfer", xfer_cnt, 107);
    pct = 50;
    for (int i = 0; i < 1000; i++) push(8'($urandom));
    wait_drain("rand1000_drain", 6000);
    chk("rand1000_xfer", xfer_cnt, 1107);
    pct = 0;
    step();
    for (int i = 0; i < 7; i++) push(8'(8'hC0 + i));
    repeat (10) step();
    chk("fl_pre_level", buf_level, 2);
    chk("fl_pre_fifo", fifo.size(), 5);
    c0 = xfer_cnt;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_m_valid", m_valid, 0);
    chk("fl_busy", flush_busy, 1);
    for (k = 0; k < 30 && flush_busy; k++) step();
    inv("fl_exit_timeout", !flush_busy);
    chk("fl_fifo_empty", fifo.size(), 0);
    chk("fl_xfer_kept", xfer_cnt, c0);
    sb.delete();
    pct = 100;
    step();
    push(8'hA5); push(8'h5A);
    wait_drain("fl_after_drain", 20);
    chk("fl_after_xfer", xfer_cnt, c0 + 2);
    for (int i = 0; i < 10; i++) push(8'(i));
    repeat (4) step();
    #1;
    reset_n = 1'b0;
    fifo.delete();
    sb.delete();
    #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_level", buf_level, 0);
    chk("arst_m_data", m_data, 0);
    chk("arst_xfer", xfer_cnt, 0);
    chk("arst_ren", ren, 0);
    chk("arst_busy", flush_busy, 0);
    chk("arst_cnt4", cnt_n, 0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      pct = tbl[i].pct;
      for (int j = 0; j < tbl[i].n; j++) push(8'($urandom));
      wait_drain("tbl_drain", 2000);
      chk("tbl_xfer", xfer_cnt, tbl[i].exp_cnt);
      chk("tbl_xfer4", cnt_n, tbl[i].exp_cnt4);
    end
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
